interface_transmit_deb_unit: RTL and testbench
==============================================

INTERFACE_TRANSMIT_DEB_UNIT -- requirements
Module: interface_transmit_deb_unit

Interface
REQ-001 SHALL have parameter SINGLE_DATA_WIDTH, default 8, width of one UART byte.
REQ-002 SHALL have parameter FULL_DATA_WIDTH, default 32, width of one debug-unit word; must be an integer multiple of SINGLE_DATA_WIDTH (NBYTES = FULL/SINGLE, default 4).
REQ-003 SHALL have port i_clk  input  1  system clock; one clock, all logic on rising edge.
REQ-004 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_fifo_empty  input  1  transmit FIFO empty flag.
REQ-006 SHALL have port i_data  input  FULL_DATA_WIDTH  FIFO head word; first-word-fall-through, valid whenever i_fifo_empty=0.
REQ-007 SHALL have port o_fifo_rd  output  1  one-cycle FIFO pop strobe.
REQ-008 SHALL have port o_data  output  SINGLE_DATA_WIDTH  byte presented to the UART transmitter.
REQ-009 SHALL have port o_tx_start  output  1  one-cycle start strobe to the UART transmitter.
REQ-010 SHALL have port i_tx_done  input  1  one-cycle pulse from the UART transmitter at end of stop bit.
REQ-011 SHALL have port o_busy  output  1  high while a word is being serialized.
REQ-012 SHALL have port o_word_done  output  1  one-cycle pulse after the last byte of a word completes.

Function
REQ-013 SHALL implement a registered FSM with states IDLE, SEND, WAIT_DONE; all outputs registered.
REQ-014 In IDLE with i_fifo_empty=0 at edge k: latch i_data into word register, clear byte index to 0, drive o_fifo_rd=1 for the cycle after edge k only, go to SEND.
REQ-015 In IDLE with i_fifo_empty=1: remain in IDLE, o_fifo_rd=0, o_tx_start=0.
REQ-016 In SEND at edge: o_data <= word byte[index], o_tx_start=1 for exactly one cycle, go to WAIT_DONE.
REQ-017 Byte order SHALL be least-significant byte first (byte[0]=word[7:0]), matching the receive-side word assembler.
REQ-018 In WAIT_DONE: hold o_data stable, o_tx_start=0; on i_tx_done=1 with index<NBYTES-1, increment index and go to SEND.
REQ-019 In WAIT_DONE on i_tx_done=1 with index=NBYTES-1: pulse o_word_done one cycle, index <= 0, go to IDLE.
REQ-020 i_tx_done SHALL be ignored in IDLE and SEND.
REQ-021 Back-to-back words: IDLE SHALL be entered for at least one cycle between words; FIFO non-empty during the last i_tx_done is sampled in IDLE on the following edge (one-cycle bubble).
REQ-022 i_data and i_fifo_empty changes while busy SHALL not affect the word in flight.
REQ-023 o_fifo_rd SHALL assert exactly once per word; never while i_fifo_empty=1 was sampled.
REQ-024 o_busy SHALL be 1 in SEND and WAIT_DONE, 0 in IDLE.
REQ-025 Latency: i_fifo_empty falling sampled at edge k -> o_fifo_rd high after edge k, first o_tx_start high after edge k+1.
REQ-026 Byte index counter width SHALL be ceil(log2(NBYTES)) bits, min 1.

Reset
REQ-027 On i_reset=1 at a clock edge: state IDLE, index 0, word register 0, o_data=0, o_tx_start=0, o_fifo_rd=0, o_busy=0, o_word_done=0.
REQ-028 Reset mid-word SHALL discard remaining bytes without issuing further o_fifo_rd or o_tx_start; the partial word is not retransmitted.
REQ-029 Reset has priority over all other inputs in the same cycle.

Verification
REQ-030 FIFO holds 0xDEADBEEF, tx_done pulsed 20 cycles after each start -> o_data sequence EF, BE, AD, DE, one o_fifo_rd, four o_tx_start, one o_word_done.
REQ-031 FIFO holds 0x11223344 then 0xAABBCCDD -> bytes 44,33,22,11,DD,CC,BB,AA; two pops; >=1 IDLE cycle between words.
REQ-032 FIFO empty, spurious i_tx_done pulses -> no o_tx_start, no o_fifo_rd, o_busy stays 0.
REQ-033 Reset asserted in WAIT_DONE after byte 1 of 0xCAFEF00D -> outputs return to reset values next cycle; no further strobes until FIFO non-empty again.
REQ-034 i_data changed to 0x00000000 while 0x12345678 in flight (no pop) -> bytes still 78,56,34,12.
REQ-035 i_tx_done held high 3 cycles in WAIT_DONE -> each high cycle treated per REQ-018/020; bench checks exactly one byte advance per SEND.

Source files
------------

// File: rtl/interface_transmit_deb_unit.sv
// Debug-unit transmit serializer: pops one FIFO word and feeds it to a UART
// transmitter one byte at a time, least-significant byte first.
module interface_transmit_deb_unit #(
  parameter int SINGLE_DATA_WIDTH = 8,
  parameter int FULL_DATA_WIDTH   = 32
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_fifo_empty,
  input  logic [FULL_DATA_WIDTH-1:0]   i_data,
  output logic                         o_fifo_rd,
  output logic [SINGLE_DATA_WIDTH-1:0] o_data,
  output logic                         o_tx_start,
  input  logic                         i_tx_done,
  output logic                         o_busy,
  output logic                         o_word_done
);

  localparam int NBYTES = FULL_DATA_WIDTH / SINGLE_DATA_WIDTH;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SEND      = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  logic [1:0]                   state_q,     state_d;
  logic [FULL_DATA_WIDTH-1:0]   word_q,      word_d;
  logic [IDX_W-1:0]             idx_q,       idx_d;
  logic [SINGLE_DATA_WIDTH-1:0] data_q,      data_d;
  logic                         tx_start_q,  tx_start_d;
  logic                         fifo_rd_q,   fifo_rd_d;
  logic                         busy_q,      busy_d;
  logic                         word_done_q, word_done_d;

  // Next-state logic; strobes default low so each lasts exactly one cycle.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    idx_d       = idx_q;
    data_d      = data_q;
    tx_start_d  = 1'b0;
    fifo_rd_d   = 1'b0;
    word_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!i_fifo_empty) begin
          word_d    = i_data;
          idx_d     = {IDX_W{1'b0}};
          fifo_rd_d = 1'b1;
          state_d   = ST_SEND;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SEND: begin
        data_d     = word_q[int'(idx_q)*SINGLE_DATA_WIDTH +: SINGLE_DATA_WIDTH];
        tx_start_d = 1'b1;
        state_d    = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // The last byte returns to IDLE, which forces a bubble between words.
        if (i_tx_done) begin
          if (idx_q == LAST_IDX) begin
            word_done_d = 1'b1;
            idx_d       = {IDX_W{1'b0}};
            state_d     = ST_IDLE;
          end else begin
            idx_d       = idx_q + IDX_ONE;
            state_d     = ST_SEND;
          end
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        idx_d   = {IDX_W{1'b0}};
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      word_q      <= {FULL_DATA_WIDTH{1'b0}};
      idx_q       <= {IDX_W{1'b0}};
      data_q      <= {SINGLE_DATA_WIDTH{1'b0}};
      tx_start_q  <= 1'b0;
      fifo_rd_q   <= 1'b0;
      busy_q      <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      tx_start_q  <= tx_start_d;
      fifo_rd_q   <= fifo_rd_d;
      busy_q      <= busy_d;
      word_done_q <= word_done_d;
    end
  end

  assign o_fifo_rd   = fifo_rd_q;
  assign o_data      = data_q;
  assign o_tx_start  = tx_start_q;
  assign o_busy      = busy_q;
  assign o_word_done = word_done_q;

endmodule

// File: tb/tb_interface_transmit_deb_unit.sv
// Scoreboard bench: a FIFO model and a UART responder drive the serializer;
// expected bytes are queued per pushed word and popped on every o_tx_start.
module tb_interface_transmit_deb_unit;

  localparam int SW = 8;
  localparam int FW = 32;
  localparam int NB = FW / SW;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic [FW-1:0] data_in;
  logic          fifo_rd;
  logic [SW-1:0] data_out;
  logic          tx_start;
  logic          tx_done;
  logic          busy;
  logic          word_done;
  logic          resp_done;
  logic          spur_done;

  assign tx_done = resp_done | spur_done;

  always #5 clk = ~clk;

  interface_transmit_deb_unit #(.SINGLE_DATA_WIDTH(SW), .FULL_DATA_WIDTH(FW)) dut (
    .i_clk(clk), .i_reset(rst), .i_fifo_empty(fifo_empty), .i_data(data_in),
    .o_fifo_rd(fifo_rd), .o_data(data_out), .o_tx_start(tx_start),
    .i_tx_done(tx_done), .o_busy(busy), .o_word_done(word_done)
  );

  int passed = 0;
  int total  = 0;

  logic [31:0] fifo_q[$];
  logic [7:0]  exp_bytes[$];
  int          words_pushed = 0;
  logic [31:0] garbage = 32'h0;
  bit          garbage_rand = 1'b1;

  int n_start = 0;
  int n_rd    = 0;
  int n_done  = 0;

  int tx_delay_min = 1;
  int tx_delay_max = 20;
  int tx_hold      = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // UART responder: pulses tx_done a random number of cycles after each start.
  initial begin
    int cnt;
    int hold_left;
    cnt = 0;
    hold_left = 0;
    resp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt = 0;
        hold_left = 0;
        resp_done = 1'b0;
      end else begin
        if (hold_left > 0) begin
          hold_left--;
          if (hold_left == 0) resp_done = 1'b0;
        end
        if (tx_start) cnt = $urandom_range(tx_delay_max, tx_delay_min);
        else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            resp_done = 1'b1;
            hold_left = tx_hold;
          end
        end
      end
    end
  end

  // Monitor: compares every presented byte and protocol rule against the scoreboard.
  initial begin
    int          bytes_in_word;
    bit          prev_rd;
    bit          prev_start;
    logic [7:0]  last_data;
    logic [7:0]  eb;
    bytes_in_word = 0;
    prev_rd = 1'b0;
    prev_start = 1'b0;
    last_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        bytes_in_word = 0;
        prev_rd = 1'b0;
        prev_start = 1'b0;
        last_data = 8'h00;
      end else begin
        if (prev_rd) check("start_after_rd", tx_start, 1);
        if (tx_start) begin
          n_start++;
          check("start_busy", busy, 1);
          check("start_one_cycle", prev_start, 0);
          check("byte_expected", exp_bytes.size() > 0, 1);
          if (exp_bytes.size() > 0) begin
            eb = exp_bytes.pop_front();
            check("byte", data_out, eb);
          end
          bytes_in_word++;
          last_data = data_out;
        end else begin
          check("data_hold", data_out, last_data);
        end
        if (fifo_rd) begin
          n_rd++;
          check("rd_busy", busy, 1);
          check("rd_not_with_done", word_done, 0);
        end
        if (word_done) begin
          n_done++;
          check("done_byte_count", bytes_in_word, NB);
          check("done_idle", busy, 0);
          bytes_in_word = 0;
        end
        prev_rd = fifo_rd;
        prev_start = tx_start;
      end
    end
  end

  // FIFO model (first-word-fall-through), updated once per cycle on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (fifo_rd) begin
      check("rd_when_nonempty", fifo_q.size() > 0, 1);
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    if (garbage_rand) garbage = $urandom;
    fifo_empty = (fifo_q.size() == 0);
    data_in = fifo_empty ? garbage : fifo_q[0];
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
    for (int i = 0; i < NB; i++) exp_bytes.push_back(8'((w >> (8 * i)) & 32'hFF));
    words_pushed++;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (fifo_q.size() == 0 && exp_bytes.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_in_budget", ok, 1);
    repeat (3) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fifo_rd"}, fifo_rd, 0);
    check({tag, "_data"}, data_out, 0);
    check({tag, "_tx_start"}, tx_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_word_done"}, word_done, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s_start, s_rd, s_done;
    bit seen;
    rst = 1'b1;
    fifo_empty = 1'b1;
    data_in = 32'h0;
    spur_done = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single word, fixed 20-cycle UART.
    tx_delay_min = 20; tx_delay_max = 20;
    s_start = n_start; s_rd = n_rd; s_done = n_done;
    push_word(32'hDEADBEEF);
    wait_idle(2000);
    check("deadbeef_pops", n_rd - s_rd, 1);
    check("deadbeef_starts", n_start - s_start, 4);
    check("deadbeef_done", n_done - s_done, 1);

    // Back-to-back words.
    tx_delay_min = 1; tx_delay_max = 20;
    s_rd = n_rd; s_done = n_done;
    push_word(32'h11223344);
    push_word(32'hAABBCCDD);
    wait_idle(3000);
    check("b2b_pops", n_rd - s_rd, 2);
    check("b2b_done", n_done - s_done, 2);

    // Empty FIFO with spurious tx_done.
    s_start = n_start; s_rd = n_rd;
    for (int i = 0; i < 12; i++) begin
      spur_done = 1'($urandom_range(1, 0));
      tick();
      check("spur_busy", busy, 0);
    end
    spur_done = 1'b0;
    check("spur_starts", n_start - s_start, 0);
    check("spur_pops", n_rd - s_rd, 0);

    // Head data cleared to zero after the pop.
    garbage_rand = 1'b0;
    garbage = 32'h0;
    push_word(32'h12345678);
    wait_idle(2000);
    garbage_rand = 1'b1;

    // tx_done held high for three cycles.
    tx_hold = 3;
    push_word($urandom);
    push_word($urandom);
    wait_idle(3000);
    tx_hold = 1;

    // Random words at random times.
    for (int w = 0; w < 20; w++) begin
      push_word($urandom);
      repeat ($urandom_range(30, 0)) tick();
    end
    wait_idle(8000);

    // Reset in the middle of a word.
    tx_delay_min = 10; tx_delay_max = 20;
    s_start = n_start;
    push_word(32'hCAFEF00D);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (n_start == s_start + 1) begin
        seen = 1'b1;
        break;
      end
    end
    check("first_byte_seen", seen, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check_reset_outputs("midword_reset");
    exp_bytes.delete();
    s_start = n_start; s_rd = n_rd;
    repeat (30) tick();
    check("post_reset_starts", n_start - s_start, 0);
    check("post_reset_pops", n_rd - s_rd, 0);

    tx_delay_min = 1; tx_delay_max = 20;
    push_word(32'h0BADCAFE);
    wait_idle(2000);

    check("final_queue_empty", exp_bytes.size(), 0);
    check("total_pops", n_rd, words_pushed);
    check("total_words_done", n_done, words_pushed - 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
